// File: rtl/warp_req_tracker_if.sv
// warp_req_tracker_if: groups the request/grant vectors, the issued-ID
// valid/ready stage and the status flags of the warp request tracker.
// Optional feature macro: GRT_CHECK_EN (adds the grt_err status flag).
interface warp_req_tracker_if #(
    parameter int NUM_WARPS = 8,
    parameter int ID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
    logic [NUM_WARPS-1:0] push;
    logic [NUM_WARPS-1:0] req;
    logic [NUM_WARPS-1:0] grt;
    logic                 out_valid;
    logic [ID_W-1:0]      out_warp_id;
    logic                 out_ready;
    logic                 overflow;
`ifdef GRT_CHECK_EN
    logic                 grt_err;

    // Tracker side: takes pushes and grants, drives requests and the issued ID
    modport master (
        input  push, grt, out_ready,
        output req, out_valid, out_warp_id, overflow, grt_err
    );

    // Environment side: instruction buffer, prioritizer and dispatch stage
    modport slave (
        output push, grt, out_ready,
        input  req, out_valid, out_warp_id, overflow, grt_err
    );
`else
    // Tracker side: takes pushes and grants, drives requests and the issued ID
    modport master (
        input  push, grt, out_ready,
        output req, out_valid, out_warp_id, overflow
    );

    // Environment side: instruction buffer, prioritizer and dispatch stage
    modport slave (
        output push, grt, out_ready,
        input  req, out_valid, out_warp_id, overflow
    );
`endif
endinterface

// File: rtl/warp_req_tracker.sv
// warp_req_tracker: keeps a saturating pending-request count per warp,
// presents the request vector to the warp-select prioritizer and registers
// the granted warp ID into a valid/ready output stage for the issue logic.
// Optional feature macro: GRT_CHECK_EN (rejects non-one-hot grants and grants
// to warps with nothing pending, flagging them on the sticky grt_err output).
module warp_req_tracker #(
    parameter int NUM_WARPS = 8,
    parameter int CNT_W     = 2,
    parameter int ID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    warp_req_tracker_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_WARPS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [ID_W-1:0]                 out_warp_id_q, out_warp_id_d;
    logic                            overflow_q, overflow_d;

    logic [NUM_WARPS-1:0] cnt_nz;
    logic [NUM_WARPS-1:0] grant_lsb;
    logic [NUM_WARPS-1:0] inc_vec;
    logic [NUM_WARPS-1:0] dec_vec;
    logic [ID_W-1:0]      grant_id;
    logic                 stage_free;
    logic                 grant_any;
    logic                 grant_accept;

`ifdef GRT_CHECK_EN
    logic                 grt_err_q, grt_err_d;
    logic                 grant_illegal;
`endif

    // The stage can take a new ID when it is empty or being drained this cycle
    assign stage_free = !out_valid_q || bus.out_ready;
    assign grant_any  = |bus.grt;
    assign grant_lsb  = bus.grt & (~bus.grt + {{(NUM_WARPS-1){1'b0}}, 1'b1});

    // Flag which warps have anything pending
    always_comb begin
        cnt_nz = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            cnt_nz[i] = |cnt_q[i];
        end
    end

    // Encode the lowest set grant bit; extra bits of a multi-hot grant are ignored
    always_comb begin
        grant_id = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (bus.grt[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end

`ifdef GRT_CHECK_EN
    // A grant is only trusted when it is one-hot and hits a warp with work pending
    always_comb begin
        grant_illegal = grant_any && stage_free &&
                        ((bus.grt != grant_lsb) || !(|(grant_lsb & cnt_nz)));
        grant_accept  = grant_any && stage_free && !grant_illegal;
        grt_err_d     = grt_err_q || grant_illegal;
    end
`else
    // Any non-zero grant is taken whenever the output stage can hold it
    always_comb begin
        grant_accept = grant_any && stage_free;
    end
`endif

    assign inc_vec = bus.push;
    assign dec_vec = {NUM_WARPS{grant_accept}} & grant_lsb & cnt_nz;

    // Net counter update: push and grant to the same warp cancel, a lone push
    // into a full counter saturates and raises the sticky overflow flag
    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Output stage: load on an accepted grant, empty on a handshake, else hold
    always_comb begin
        out_valid_d   = out_valid_q;
        out_warp_id_d = out_warp_id_q;
        if (grant_accept) begin
            out_valid_d   = 1'b1;
            out_warp_id_d = grant_id;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset wins over any same-cycle push or grant
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_warp_id_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_warp_id_q <= out_warp_id_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef GRT_CHECK_EN
    // Sticky grant-protocol error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            grt_err_q <= 1'b0;
        end else begin
            grt_err_q <= grt_err_d;
        end
    end

    assign bus.grt_err = grt_err_q;
`endif

    // Requests are masked while the output stage is blocked so nothing is granted
    assign bus.req         = cnt_nz & {NUM_WARPS{stage_free}};
    assign bus.out_valid   = out_valid_q;
    assign bus.out_warp_id = out_warp_id_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_warp_req_tracker.sv
// tb_warp_req_tracker: directed scenarios with literal expectations followed
// by a randomized run, all checked every cycle against a count-based model.
// Optional feature macro: GRT_CHECK_EN (expects grant checking and grt_err).
module tb_warp_req_tracker;
    localparam int NW      = 8;
    localparam int CNT_MAX = 3;

    logic       clk;
    logic       rst;
    logic       loopback;
    logic [7:0] grt_drv;

    int errors = 0;
    int checks = 0;

    // Behavioural model: plain integer counts and the issued-ID stage
    int  m_cnt [NW];
    bit  m_valid;
    int  m_id;
    bit  m_ovf;
    bit  m_err;
    bit  model_live = 0;

    int         mdl_w;
    bit         mdl_acc;
    int         mdl_n;
    logic [7:0] mdl_g;

    warp_req_tracker_if #(.NUM_WARPS(NW), .ID_W(3)) bus_if ();

    warp_req_tracker #(.NUM_WARPS(NW), .CNT_W(2), .ID_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Loopback mimics a prioritizer that grants the lowest requesting warp
    assign bus_if.grt = loopback ? (bus_if.req & (~bus_if.req + 8'd1)) : grt_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] p, input logic [7:0] g, input bit lb, input bit r);
        bus_if.push      = p;
        grt_drv          = g;
        loopback         = lb;
        bus_if.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] modelReq();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) begin
            v[i] = (m_cnt[i] > 0) && (!m_valid || bus_if.out_ready);
        end
        return v;
    endfunction

    // Model update from the inputs that were present at this rising edge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) m_cnt[i] = 0;
            m_valid    = 0;
            m_id       = 0;
            m_ovf      = 0;
            m_err      = 0;
            model_live = 1;
        end else if (model_live) begin
            mdl_g   = bus_if.grt;
            mdl_acc = 0;
            mdl_w   = 0;
            for (int i = NW - 1; i >= 0; i--) begin
                if (mdl_g[i]) mdl_w = i;
            end
            if (mdl_g != 0 && (!m_valid || bus_if.out_ready)) begin
`ifdef GRT_CHECK_EN
                if ($countones(mdl_g) != 1 || m_cnt[mdl_w] == 0) m_err = 1;
                else mdl_acc = 1;
`else
                mdl_acc = 1;
`endif
            end
            for (int i = 0; i < NW; i++) begin
                mdl_n = m_cnt[i] + int'(bus_if.push[i]);
                if (mdl_acc && mdl_w == i && m_cnt[i] > 0) mdl_n = mdl_n - 1;
                if (mdl_n > CNT_MAX) begin
                    mdl_n = CNT_MAX;
                    m_ovf = 1;
                end
                m_cnt[i] = mdl_n;
            end
            if (mdl_acc) begin
                m_valid = 1;
                m_id    = mdl_w;
            end else if (bus_if.out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, mid-cycle
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("req", 32'(bus_if.req), 32'(modelReq()));
            checkOutput("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
            if (m_valid) checkOutput("out_warp_id", 32'(bus_if.out_warp_id), 32'(m_id));
            checkOutput("overflow", 32'(bus_if.overflow), 32'(m_ovf));
`ifdef GRT_CHECK_EN
            checkOutput("grt_err", 32'(bus_if.grt_err), 32'(m_err));
`endif
        end
    end

    initial begin
        logic [7:0] p;
        logic [7:0] g;
        bit         lb;
        bit         r;

        rst              = 1'b1;
        loopback         = 1'b0;
        grt_drv          = '0;
        bus_if.push      = '0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset then idle
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'h00, 8'h00, 0, 0);
            checkOutput("idle_req", 32'(bus_if.req), 32'h0);
            checkOutput("idle_valid", 32'(bus_if.out_valid), 32'h0);
            checkOutput("idle_overflow", 32'(bus_if.overflow), 32'h0);
        end

        // Single request on warp 2 with loopback grant
        applyStimulus(8'h04, 8'h00, 1, 1);
        checkOutput("single_req", 32'(bus_if.req), 32'h04);
        checkOutput("single_valid_early", 32'(bus_if.out_valid), 32'h0);
        applyStimulus(8'h00, 8'h00, 1, 1);
        checkOutput("single_valid", 32'(bus_if.out_valid), 32'h1);
        checkOutput("single_id", 32'(bus_if.out_warp_id), 32'h2);
        checkOutput("single_req_done", 32'(bus_if.req), 32'h0);
        applyStimulus(8'h00, 8'h00, 1, 1);
        checkOutput("single_drain", 32'(bus_if.out_valid), 32'h0);

        // Backpressure on warp 5
        applyStimulus(8'h20, 8'h00, 1, 0);
        applyStimulus(8'h20, 8'h00, 1, 0);
        applyStimulus(8'h20, 8'h00, 1, 0);
        checkOutput("bp_valid", 32'(bus_if.out_valid), 32'h1);
        checkOutput("bp_id", 32'(bus_if.out_warp_id), 32'h5);
        checkOutput("bp_req_masked", 32'(bus_if.req), 32'h0);
        applyStimulus(8'h00, 8'h00, 1, 0);
        checkOutput("bp_hold_id", 32'(bus_if.out_warp_id), 32'h5);
        applyStimulus(8'h00, 8'h00, 1, 1);
        checkOutput("bp_second_valid", 32'(bus_if.out_valid), 32'h1);
        checkOutput("bp_second_id", 32'(bus_if.out_warp_id), 32'h5);
        applyStimulus(8'h00, 8'h00, 1, 1);
        checkOutput("bp_third_valid", 32'(bus_if.out_valid), 32'h1);
        checkOutput("bp_third_id", 32'(bus_if.out_warp_id), 32'h5);
        applyStimulus(8'h00, 8'h00, 1, 1);
        checkOutput("bp_empty", 32'(bus_if.out_valid), 32'h0);

        // Saturation of warp 0
        for (int k = 0; k < 3; k++) applyStimulus(8'h01, 8'h00, 0, 1);
        checkOutput("sat_no_overflow_yet", 32'(bus_if.overflow), 32'h0);
        applyStimulus(8'h01, 8'h00, 0, 1);
        checkOutput("sat_overflow", 32'(bus_if.overflow), 32'h1);
        applyStimulus(8'h00, 8'h00, 0, 1);
        checkOutput("sat_overflow_sticky", 32'(bus_if.overflow), 32'h1);
        checkOutput("sat_req", 32'(bus_if.req), 32'h01);
        for (int k = 0; k < 4; k++) applyStimulus(8'h00, 8'h00, 1, 1);
        checkOutput("sat_drained", 32'(bus_if.req), 32'h0);

        // Simultaneous push and grant on warp 1
        applyStimulus(8'h02, 8'h00, 0, 1);
        applyStimulus(8'h02, 8'h00, 1, 1);
        checkOutput("simul_id", 32'(bus_if.out_warp_id), 32'h1);
        checkOutput("simul_req_kept", 32'(bus_if.req), 32'h02);
        applyStimulus(8'h00, 8'h00, 1, 1);
        checkOutput("simul_second_id", 32'(bus_if.out_warp_id), 32'h1);
        checkOutput("simul_second_valid", 32'(bus_if.out_valid), 32'h1);
        applyStimulus(8'h00, 8'h00, 1, 1);

        // Multi-hot grant and grant to an empty warp
        applyStimulus(8'h00, 8'h03, 0, 1);
`ifdef GRT_CHECK_EN
        checkOutput("multihot_err", 32'(bus_if.grt_err), 32'h1);
        checkOutput("multihot_valid", 32'(bus_if.out_valid), 32'h0);
`else
        checkOutput("multihot_valid", 32'(bus_if.out_valid), 32'h1);
        checkOutput("multihot_id", 32'(bus_if.out_warp_id), 32'h0);
`endif
        applyStimulus(8'h00, 8'h08, 0, 1);
`ifdef GRT_CHECK_EN
        checkOutput("empty_grant_err", 32'(bus_if.grt_err), 32'h1);
        checkOutput("empty_grant_valid", 32'(bus_if.out_valid), 32'h0);
`else
        checkOutput("empty_grant_valid", 32'(bus_if.out_valid), 32'h1);
        checkOutput("empty_grant_id", 32'(bus_if.out_warp_id), 32'h3);
`endif
        applyStimulus(8'h00, 8'h00, 0, 1);
        checkOutput("empty_grant_no_req", 32'(bus_if.req), 32'h0);

        // Randomized traffic with occasional resets and arbitrary grants
        rst = 1'b1;
        applyStimulus(8'h00, 8'h00, 0, 1);
        rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            p = '0;
            for (int b = 0; b < NW; b++) begin
                if ($urandom_range(0, 9) == 0) p[b] = 1'b1;
            end
            lb = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) g = 8'($urandom);
            else g = 8'(1) << $urandom_range(0, 7);
            r   = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            applyStimulus(p, g, lb, r);
        end
        rst = 1'b0;
        applyStimulus(8'h00, 8'h00, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/warp_req_tracker.md
# warp_req_tracker

Requester-side companion to the warp-select prioritizer. It keeps a per-warp count of pending issue requests and drives the one-hot-per-warp request vector into the prioritizer. It consumes the one-hot grant, encodes it to a warp ID, and presents that ID through a registered valid/ready output stage to the issue logic. It sits between the instruction buffer (which pushes requests) and the dispatch stage.

## Interface
- NUM_WARPS, 8, number of warps; one request/grant bit per warp
- CNT_W, 2, width of each per-warp pending counter; maximum pending per warp is 2^CNT_W-1
- ID_W, $clog2(NUM_WARPS) (minimum 1), width of the encoded warp ID

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- push  in  NUM_WARPS  bit i adds one pending request for warp i this cycle
- req  out  NUM_WARPS  request vector to the prioritizer (combinational)
- grt  in  NUM_WARPS  grant vector from the prioritizer, expected one-hot or zero
- out_valid  out  1  output stage holds a granted warp ID
- out_warp_id  out  ID_W  encoded ID of the granted warp
- out_ready  in  1  downstream accepts the ID when high together with out_valid
- overflow  out  1  sticky flag: a push arrived while that warp's counter was saturated
- grt_err  out  1  sticky grant-protocol error flag; present only when GRT_CHECK_EN is defined

## Operation
- stage_free = !out_valid | out_ready.
- req[i] = (cnt[i] != 0) & stage_free. When the output stage is blocked, all requests are masked.
- Accepted grant: grt != 0 and stage_free. Warp w is the lowest set bit of grt.
- Per-warp counter update each cycle: cnt[i] += push[i], then cnt[i] -= (accepted grant and w == i and cnt[i] != 0).
- Push and grant to the same warp in the same cycle leave the counter unchanged.
- Push with cnt[i] at maximum and no decrement that cycle: counter saturates (stays at maximum) and overflow is set. Push with cnt at maximum plus a grant to that warp: the push is absorbed and the count stays at maximum, with no overflow.
- Grant to a warp whose counter is 0: the counter does not underflow and stays 0. The ID is still issued unless GRT_CHECK_EN rejects the grant.
- Output stage: on an accepted grant, out_valid <= 1 and out_warp_id <= w. Otherwise, if out_ready, out_valid <= 0. out_warp_id holds its value while out_valid=1 && !out_ready.
- Back-to-back: with out_ready held high, one ID is issued per cycle.

## Timing
- Reset values: all counters 0, out_valid 0, out_warp_id 0, overflow 0, grt_err 0. req is therefore 0 in the cycle after reset.
- rst has priority over push and grt in the same cycle; any in-flight ID is discarded.
- Latency: a push in cycle N makes req[i]=1 in cycle N+1. A grant in cycle N+1 makes out_valid=1 with the ID in cycle N+2.
- req depends combinationally on out_ready. grt may depend combinationally on req, so the path out_ready -> req -> grt must be closed within one cycle, and downstream must not derive out_ready from req.

## Configuration
- GRT_CHECK_EN defined: a grant is illegal if it is non-one-hot or targets a warp with cnt == 0. An illegal grant sets grt_err (sticky until rst), is not accepted, leaves counters unchanged, and loads no output.
- GRT_CHECK_EN undefined: the grt_err port does not exist. Non-one-hot grants are resolved to the lowest set bit. Grants to zero-count warps issue the ID without decrementing.

## Test plan
- Reset then idle: rst high for 2 cycles, then low -> req=0, out_valid=0, overflow=0 for 5 cycles.
- Single request: push=8'b0000_0100 for 1 cycle, loopback grt=req, out_ready=1 -> req[2]=1 next cycle, out_valid=1 with out_warp_id=2 one cycle later, then req=0.
- Backpressure: fill warp 5 with 3 pushes, out_ready=0 -> first ID 5 holds, req=0 while stalled, cnt[5]=2. Raise out_ready -> IDs 5, 5 follow on consecutive cycles.
- Saturation: push warp 0 four times with grt=0 -> cnt[0]=3, overflow=1 after the fourth push and remains 1.
- Simultaneous push and grant to warp 1 with cnt[1]=1 -> cnt[1] stays 1 and ID 1 is issued.
- GRT_CHECK_EN: grt=8'b0000_0011, or a grant to a warp with cnt=0 -> grt_err=1, out_valid stays 0, counters unchanged. Without the macro, grt=8'b0000_0011 issues ID 0.
